// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY        = 2'b00;
  localparam logic [31:0]       RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // Instruction word held for decode together with its response status.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic              err;
  } fetch_word_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch PC register: reset value, sequential +4 advance and redirect override.
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] fetch_pc_next_c
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // Redirect wins over advance; the add wraps naturally at the top of the space.
  always_comb begin
    fetch_pc_next_c = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_next_c = redirect_pc;
    end else if (advance) begin
      fetch_pc_next_c = fetch_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
    end else begin
      fetch_pc <= fetch_pc_next_c;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one read per instruction, holds the word until decode
// accepts it, and flushes in-flight or held fetches on redirect.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [INST_W-1:0] rdata,
  input  logic [RESP_W-1:0] rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_err,
  output logic              IFU_valid,
  input  logic              IDU_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_e      state_q, state_d;
  logic              drop_q, drop_d;
  fetch_word_t       word_q;
  logic              capture_c;
  logic              advance_c;
  logic              req_load_c;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next_c;
  logic [ADDR_W-1:0] req_pc_q;

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .advance         (advance_c),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_pc        (fetch_pc),
    .fetch_pc_next_c (fetch_pc_next_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
    end else if (capture_c) begin
      word_q <= '{inst: rdata, err: (rresp != RESP_OKAY)};
    end
  end

  // Address of the outstanding request; frozen while a stale request waits for arready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc_q <= RESET_PC;
    end else if (req_load_c) begin
      req_pc_q <= fetch_pc_next_c;
    end
  end

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    capture_c = 1'b0;
    advance_c = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) drop_d = 1'b1;
        if (arready) state_d = S_RESP;
      end
      S_RESP: begin
        if (rvalid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            capture_c = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (IDU_ready) begin
          advance_c = 1'b1;
          state_d   = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
    req_load_c = (state_q != S_REQ) && (state_d == S_REQ);
  end

  assign arvalid   = rst && (state_q == S_REQ);
  assign araddr    = req_pc_q;
  assign rready    = (state_q == S_RESP);
  assign IFU_valid = (state_q == S_HOLD) && !redirect_valid;
  assign inst      = word_q.inst;
  assign inst_err  = word_q.err;
  assign pc        = fetch_pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch with a behavioural instruction memory.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_err;
  logic        IFU_valid;
  logic        IDU_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  // memory knobs, written only between clock edges
  int          r_delay = 0;
  int          ar_hold = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  // memory internal state
  bit          mem_pending = 0;
  logic [31:0] mem_addr = '0;
  int          mem_wait = 0;
  bit          ar_fire = 0;
  bit          r_fire = 0;
  logic [31:0] ar_addr_seen = '0;

  ifu_fetch #(.ADDR_W(32), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .inst           (inst),
    .pc             (pc),
    .inst_err       (inst_err),
    .IFU_valid      (IFU_valid),
    .IDU_ready      (IDU_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory slave: drives on the falling edge, records handshakes just after.
  initial begin : mem_slave
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_pending = 0;
        arready = 1'b0;
        rvalid  = 1'b0;
        ar_fire = 0;
        r_fire  = 0;
      end else begin
        if (r_fire) rvalid = 1'b0;
        if (ar_fire) begin
          mem_pending = 1;
          mem_addr    = ar_addr_seen;
          mem_wait    = r_delay;
        end
        if (mem_pending && !rvalid) begin
          if (mem_wait == 0) begin
            rvalid      = 1'b1;
            rdata       = mem_word(mem_addr);
            rresp       = (mem_addr == err_addr) ? 2'b10 : 2'b00;
            mem_pending = 0;
          end else begin
            mem_wait--;
          end
        end
        if (arvalid && !mem_pending && !rvalid) begin
          if (ar_hold > 0) begin
            arready = 1'b0;
            ar_hold--;
          end else begin
            arready = 1'b1;
          end
        end else begin
          arready = 1'b0;
        end
        #1;
        ar_fire      = arvalid && arready;
        ar_addr_seen = araddr;
        r_fire       = rvalid && rready;
      end
    end
  end

  // Call at a falling edge; returns 1ns after the falling edge where the condition holds.
  task automatic wait_cond(input int sel, input int max_cycles, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cycles; i++) begin
      #1;
      if ((sel == 0 && IFU_valid) || (sel == 1 && arvalid) || (sel == 2 && rready)) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_addr;
    rst = 1'b0; IDU_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got=%b exp=0", rready); end
    checks++; if (IFU_valid !== 1'b0) begin errors++; $display("FAIL reset_ifu_valid got=%b exp=0", IFU_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst); end
    checks++; if (inst_err !== 1'b0) begin errors++; $display("FAIL reset_inst_err got=%b exp=0", inst_err); end
    checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got=%h exp=80000000", pc); end
    @(posedge clk); #2;
    rst = 1'b1; IDU_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); #1;
      exp_addr = 32'h8000_0000 + 32'(4 * (c / 3));
      checks++; if (arvalid !== (c % 3 == 0)) begin errors++; $display("FAIL boot_arvalid c=%0d got=%b", c, arvalid); end
      checks++; if (rready !== (c % 3 == 1)) begin errors++; $display("FAIL boot_rready c=%0d got=%b", c, rready); end
      checks++; if (IFU_valid !== (c % 3 == 2)) begin errors++; $display("FAIL boot_ifu_valid c=%0d got=%b", c, IFU_valid); end
      if (c % 3 == 0) begin
        checks++; if (araddr !== exp_addr) begin errors++; $display("FAIL boot_araddr c=%0d got=%h exp=%h", c, araddr, exp_addr); end
      end
      if (c % 3 == 2) begin
        checks++; if (pc !== exp_addr) begin errors++; $display("FAIL boot_pc c=%0d got=%h exp=%h", c, pc, exp_addr); end
        checks++; if (inst !== mem_word(exp_addr)) begin errors++; $display("FAIL boot_inst c=%0d got=%h exp=%h", c, inst, mem_word(exp_addr)); end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] pc0, inst0;
    @(negedge clk); IDU_ready = 1'b0;
    wait_cond(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_wait got=timeout exp=IFU_valid"); end
    pc0 = pc; inst0 = inst;
    checks++; if (pc0 !== 32'h8000_000C) begin errors++; $display("FAIL stall_pc got=%h exp=8000000c", pc0); end
    checks++; if (inst0 !== mem_word(32'h8000_000C)) begin errors++; $display("FAIL stall_inst got=%h exp=%h", inst0, mem_word(32'h8000_000C)); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if (IFU_valid !== 1'b1 || pc !== pc0 || inst !== inst0 || arvalid !== 1'b0) begin
        errors++; $display("FAIL stall_hold k=%0d got valid=%b pc=%h inst=%h arvalid=%b exp valid=1 pc=%h inst=%h arvalid=0",
                           k, IFU_valid, pc, inst, arvalid, pc0, inst0);
      end
    end
    @(negedge clk); IDU_ready = 1'b1; #1;
    checks++; if (IFU_valid !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", IFU_valid); end
    @(negedge clk);
    wait_cond(0, 20, ok);
    checks++; if (!ok || pc !== pc0 + 32'd4) begin errors++; $display("FAIL stall_next_pc got=%h exp=%h", pc, pc0 + 32'd4); end
  endtask

  task automatic test_redirect_resp();
    bit ok;
    r_delay = 3;
    @(negedge clk);
    wait_cond(2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rresp_wait got=timeout exp=rready"); end
    r_delay = 0;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; #1;
    checks++; if (rready !== 1'b1 || IFU_valid !== 1'b0) begin errors++; $display("FAIL rresp_state got rready=%b valid=%b exp rready=1 valid=0", rready, IFU_valid); end
    @(negedge clk); redirect_valid = 1'b0;
    wait_cond(1, 20, ok);
    checks++; if (!ok || araddr !== 32'h8000_0100) begin errors++; $display("FAIL rresp_araddr got=%h exp=80000100", araddr); end
    @(negedge clk);
    wait_cond(0, 20, ok);
    checks++; if (!ok || pc !== 32'h8000_0100) begin errors++; $display("FAIL rresp_pc got=%h exp=80000100", pc); end
    checks++; if (inst !== mem_word(32'h8000_0100)) begin errors++; $display("FAIL rresp_inst got=%h exp=%h", inst, mem_word(32'h8000_0100)); end
  endtask

  task automatic test_redirect_req();
    bit ok;
    ar_hold = 4;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0104) begin errors++; $display("FAIL rreq_first got arvalid=%b araddr=%h exp 1 80000104", arvalid, araddr); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); redirect_valid = 1'b0; #1;
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h8000_0104 || arready !== 1'b0) begin
        errors++; $display("FAIL rreq_stable k=%0d got arvalid=%b araddr=%h exp 1 80000104", k, arvalid, araddr);
      end
    end
    @(negedge clk); #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0104) begin errors++; $display("FAIL rreq_accept got arvalid=%b araddr=%h exp 1 80000104", arvalid, araddr); end
    @(negedge clk);
    wait_cond(1, 20, ok);
    checks++; if (!ok || araddr !== 32'h8000_0200) begin errors++; $display("FAIL rreq_araddr got=%h exp=80000200", araddr); end
    @(negedge clk);
    wait_cond(0, 20, ok);
    checks++; if (!ok || pc !== 32'h8000_0200) begin errors++; $display("FAIL rreq_pc got=%h exp=80000200", pc); end
    checks++; if (inst !== mem_word(32'h8000_0200)) begin errors++; $display("FAIL rreq_inst got=%h exp=%h", inst, mem_word(32'h8000_0200)); end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    @(negedge clk); IDU_ready = 1'b0;
    wait_cond(0, 20, ok);
    checks++; if (!ok || pc !== 32'h8000_0204) begin errors++; $display("FAIL rhold_pc got=%h exp=80000204", pc); end
    @(negedge clk); IDU_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300; #1;
    checks++; if (IFU_valid !== 1'b0) begin errors++; $display("FAIL rhold_mask got=%b exp=0", IFU_valid); end
    @(negedge clk); redirect_valid = 1'b0;
    wait_cond(1, 20, ok);
    checks++; if (!ok || araddr !== 32'h8000_0300) begin errors++; $display("FAIL rhold_araddr got=%h exp=80000300", araddr); end
    @(negedge clk);
    wait_cond(0, 20, ok);
    checks++; if (!ok || pc !== 32'h8000_0300 || inst !== mem_word(32'h8000_0300)) begin
      errors++; $display("FAIL rhold_word got pc=%h inst=%h exp pc=80000300 inst=%h", pc, inst, mem_word(32'h8000_0300));
    end
  endtask

  task automatic test_err();
    bit ok;
    err_addr = 32'h8000_0304;
    @(negedge clk);
    wait_cond(0, 20, ok);
    checks++; if (!ok || pc !== 32'h8000_0304) begin errors++; $display("FAIL err_pc got=%h exp=80000304", pc); end
    checks++; if (inst_err !== 1'b1) begin errors++; $display("FAIL err_flag got=%b exp=1", inst_err); end
    @(negedge clk);
    wait_cond(0, 20, ok);
    checks++; if (!ok || pc !== 32'h8000_0308) begin errors++; $display("FAIL err_next_pc got=%h exp=80000308", pc); end
    checks++; if (inst_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", inst_err); end
  endtask

  task automatic test_wrap();
    bit ok;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); redirect_valid = 1'b0;
    wait_cond(0, 20, ok);
    checks++; if (!ok || pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_pc got=%h exp=fffffffc", pc); end
    @(negedge clk);
    wait_cond(1, 20, ok);
    checks++; if (!ok || araddr !== 32'h0) begin errors++; $display("FAIL wrap_araddr got=%h exp=00000000", araddr); end
    @(negedge clk);
    wait_cond(0, 20, ok);
    checks++; if (!ok || pc !== 32'h0 || inst !== mem_word(32'h0)) begin
      errors++; $display("FAIL wrap_word got pc=%h inst=%h exp pc=0 inst=%h", pc, inst, mem_word(32'h0));
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    r_delay = 3;
    @(negedge clk);
    wait_cond(2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_wait got=timeout exp=rready"); end
    #2; rst = 1'b0; #1;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || IFU_valid !== 1'b0 || inst !== 32'h0 ||
        inst_err !== 1'b0 || pc !== 32'h8000_0000) begin
      errors++; $display("FAIL rstmid_outputs got arvalid=%b rready=%b valid=%b inst=%h err=%b pc=%h exp 0 0 0 0 0 80000000",
                         arvalid, rready, IFU_valid, inst, inst_err, pc);
    end
    r_delay = 0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #2; rst = 1'b1;
    @(negedge clk);
    wait_cond(0, 20, ok);
    checks++; if (!ok || pc !== 32'h8000_0000 || inst !== 32'h0000_0413) begin
      errors++; $display("FAIL rstmid_refetch got pc=%h inst=%h exp 80000000 00000413", pc, inst);
    end
  endtask

  // Random traffic against an in-order model: each accepted word is the next
  // sequential PC, restarted at the most recent redirect target.
  task automatic test_random();
    logic [31:0] exp_pc;
    int          hs;
    logic        prev_arvalid, prev_arready;
    logic [31:0] prev_araddr;
    exp_pc = '0; hs = 0; prev_arvalid = 0; prev_arready = 0; prev_araddr = '0;
    err_addr = 32'h8000_0040;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      IDU_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = (i == 0) || ($urandom_range(0, 11) == 0);
      redirect_pc    = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
      #1;
      if (redirect_valid) begin
        checks++; if (IFU_valid !== 1'b0) begin errors++; $display("FAIL rnd_mask i=%0d got=%b exp=0", i, IFU_valid); end
      end
      if (IFU_valid && IDU_ready) begin
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, pc, exp_pc); end
        checks++; if (inst !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_inst i=%0d got=%h exp=%h", i, inst, mem_word(exp_pc)); end
        checks++; if (inst_err !== (exp_pc == err_addr)) begin errors++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, inst_err, exp_pc == err_addr); end
        exp_pc = exp_pc + 32'd4;
        hs++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      if (prev_arvalid && !prev_arready) begin
        checks++;
        if (arvalid !== 1'b1 || araddr !== prev_araddr) begin
          errors++; $display("FAIL rnd_ar_stable i=%0d got arvalid=%b araddr=%h exp 1 %h", i, arvalid, araddr, prev_araddr);
        end
      end
      checks++;
      if (arvalid && (mem_pending || rvalid)) begin
        errors++; $display("FAIL rnd_outstanding i=%0d got=2 requests exp=1", i);
      end
      prev_arvalid = arvalid; prev_arready = arready; prev_araddr = araddr;
      r_delay = $urandom_range(0, 3);
      ar_hold = $urandom_range(0, 2);
    end
    @(negedge clk); redirect_valid = 1'b0;
    checks++; if (hs < 40) begin errors++; $display("FAIL rnd_progress got=%0d exp>=40", hs); end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect_resp();
    test_redirect_req();
    test_redirect_hold();
    test_err();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
